// File: rtl/gfx_err_monitor_pkg.sv
// Shared display width, channel-index type and counter-to-display mapping for gfx_err_monitor.
// Pure definitions: no state, no latency, no flow control.
package gfx_err_monitor_pkg;

  localparam int DISP_W   = 16;
  localparam int CH_IDX_W = 8;

  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  // Callers zero-extend the counter to 64 bits, so narrow counters pass straight through.
  function automatic logic [DISP_W-1:0] to_disp16(input logic [63:0] cnt);
    logic [DISP_W-1:0] v;
    if (|cnt[63:DISP_W]) v = '1;
    else                 v = cnt[DISP_W-1:0];
    return v;
  endfunction

endpackage

// File: rtl/gfx_err_monitor_chan.sv
// One saturating error counter; count visible one cycle after the event, no backpressure.
// GFX_ERR_MONITOR_EDGE_EN selects rising-edge events instead of level events.
module gfx_err_monitor_chan #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 err,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 sat,
  output logic                 evt
);

`ifdef GFX_ERR_MONITOR_EDGE_EN
  logic prev;

  // prev tracks the raw input even during clr so a held level is not recounted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= err;
  end

  assign evt = err & ~prev;
`else
  assign evt = err;
`endif

  // The counter can only leave all-ones through clr, so this flag is sticky by construction.
  assign sat = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (evt && !sat) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/gfx_err_monitor.sv
// Error counter bank with a rotating 16-bit display; display lags a counted event by 2 cycles.
// No backpressure. GFX_ERR_MONITOR_EDGE_EN switches the channels to rising-edge events.
module gfx_err_monitor
  import gfx_err_monitor_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int CNT_WIDTH    = 16,
  parameter int DWELL_CYCLES = 25_000_000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CH-1:0]               err_i,
  input  logic                            clr,
  input  logic                            disp_hold,
  output logic [($clog2(NUM_CH)|1)-1:0]   disp_ch,
  output logic [7:0]                      disp_hi,
  output logic [7:0]                      disp_lo,
  output logic [NUM_CH-1:0]               sat,
  output logic                            any_err
);

  localparam int                CH_W       = $clog2(NUM_CH) | 1;
  localparam int                DW_W       = $clog2(DWELL_CYCLES);
  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam ch_idx_t           CH_LAST    = ch_idx_t'(NUM_CH - 1);

  logic [CNT_WIDTH-1:0] cnt [NUM_CH];
  logic [NUM_CH-1:0]    evt;
  logic [DW_W-1:0]      dwell;
  ch_idx_t              ch_q;
  logic [CNT_WIDTH-1:0] sel_cnt;
  logic [DISP_W-1:0]    disp_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    gfx_err_monitor_chan #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .err   (err_i[i]),
      .clr   (clr),
      .cnt   (cnt[i]),
      .sat   (sat[i]),
      .evt   (evt[i])
    );
  end

  // Rotation deliberately ignores clr so the display cadence never jumps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
      ch_q  <= '0;
    end else if (!disp_hold) begin
      if (dwell == DWELL_LAST) begin
        dwell <= '0;
        ch_q  <= (ch_q == CH_LAST) ? '0 : ch_q + ch_idx_t'(1);
      end else begin
        dwell <= dwell + DW_W'(1);
      end
    end
  end

  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == ch_idx_t'(i)) sel_cnt = cnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) disp_q <= '0;
    else        disp_q <= to_disp16(64'(sel_cnt));
  end

  // clr takes priority, so an event coinciding with clr never sets the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      any_err <= 1'b0;
    else if (clr)    any_err <= 1'b0;
    else if (|evt)   any_err <= 1'b1;
  end

  assign disp_ch = ch_q[CH_W-1:0];
  assign disp_hi = disp_q[15:8];
  assign disp_lo = disp_q[7:0];

endmodule

// File: tb/tb_gfx_err_monitor.sv
module tb_gfx_err_monitor;

  localparam int N    = 2;
  localparam int W    = 4;
  localparam int D    = 4;
  localparam int MAXC = (1 << W) - 1;

  logic       clk;
  logic       rst_n;
  logic [1:0] err_i;
  logic       clr;
  logic       disp_hold;
  logic [0:0] disp_ch;
  logic [7:0] disp_hi, disp_lo;
  logic [1:0] sat;
  logic       any_err;

  logic [1:0] err_b;
  logic       hold_b;
  logic       clr_b;
  logic [0:0] disp_ch_b;
  logic [7:0] disp_hi_b, disp_lo_b;
  logic [1:0] sat_b;
  logic       any_b;

  gfx_err_monitor #(.NUM_CH(N), .CNT_WIDTH(W), .DWELL_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .err_i(err_i), .clr(clr), .disp_hold(disp_hold),
    .disp_ch(disp_ch), .disp_hi(disp_hi), .disp_lo(disp_lo), .sat(sat), .any_err(any_err)
  );

  gfx_err_monitor #(.NUM_CH(2), .CNT_WIDTH(20), .DWELL_CYCLES(4)) dut_wide (
    .clk(clk), .rst_n(rst_n), .err_i(err_b), .clr(clr_b), .disp_hold(hold_b),
    .disp_ch(disp_ch_b), .disp_hi(disp_hi_b), .disp_lo(disp_lo_b), .sat(sat_b), .any_err(any_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: counts per channel, total non-held cycles, and the sampled display value.
  int m_cnt [N];
  bit m_prev[N];
  int m_adv;
  bit m_any;
  int m_disp;

  function automatic int m_ch();
    return (m_adv / D) % N;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i]  = 0;
      m_prev[i] = 0;
    end
    m_adv  = 0;
    m_any  = 0;
    m_disp = 0;
  endtask

  task automatic model_step();
    bit e [N];
    m_disp = m_cnt[m_ch()];
    for (int i = 0; i < N; i++) begin
`ifdef GFX_ERR_MONITOR_EDGE_EN
      e[i] = err_i[i] && !m_prev[i];
`else
      e[i] = err_i[i];
`endif
      m_prev[i] = err_i[i];
    end
    if (clr) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_any = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (e[i]) begin
          m_any = 1;
          if (m_cnt[i] < MAXC) m_cnt[i]++;
        end
      end
    end
    if (!disp_hold) m_adv++;
  endtask

  task automatic tick();
    logic [1:0] s;
    @(posedge clk);
    model_step();
    #1;
    s = {m_cnt[1] == MAXC, m_cnt[0] == MAXC};
    chk("disp_ch", 32'(disp_ch), 32'(m_ch()));
    chk("disp_val", {16'h0, disp_hi, disp_lo}, 32'(m_disp));
    chk("sat", 32'(sat), 32'(s));
    chk("any_err", 32'(any_err), 32'(m_any));
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] err;
    logic       clr;
    logic       hold;
    int         ch;
    int         lo;
    logic [1:0] sat;
    logic       any;
  } vec_t;

  vec_t tbl [12];

  initial begin
    bit reached;

    tbl[0]  = '{2'b01, 1'b0, 1'b0, 0, 0, 2'b00, 1'b1};
    tbl[1]  = '{2'b00, 1'b0, 1'b0, 0, 1, 2'b00, 1'b1};
    tbl[2]  = '{2'b10, 1'b0, 1'b0, 0, 1, 2'b00, 1'b1};
    tbl[3]  = '{2'b00, 1'b0, 1'b0, 1, 1, 2'b00, 1'b1};
    tbl[4]  = '{2'b00, 1'b0, 1'b0, 1, 1, 2'b00, 1'b1};
    tbl[5]  = '{2'b10, 1'b0, 1'b0, 1, 1, 2'b00, 1'b1};
    tbl[6]  = '{2'b00, 1'b0, 1'b0, 1, 2, 2'b00, 1'b1};
    tbl[7]  = '{2'b01, 1'b1, 1'b0, 0, 2, 2'b00, 1'b0};
    tbl[8]  = '{2'b00, 1'b0, 1'b0, 0, 0, 2'b00, 1'b0};
    tbl[9]  = '{2'b01, 1'b0, 1'b1, 0, 0, 2'b00, 1'b1};
    tbl[10] = '{2'b00, 1'b0, 1'b1, 0, 1, 2'b00, 1'b1};
    tbl[11] = '{2'b00, 1'b0, 1'b1, 0, 1, 2'b00, 1'b1};

    rst_n = 1'b0; err_i = '0; clr = 1'b0; disp_hold = 1'b0;
    err_b = '0; clr_b = 1'b0; hold_b = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_disp_ch", 32'(disp_ch), 0);
    chk("rst_disp", {16'h0, disp_hi, disp_lo}, 0);
    chk("rst_sat", 32'(sat), 0);
    chk("rst_any", 32'(any_err), 0);
    rst_n = 1'b1;

    // Directed table, pulses only, so level and edge modes agree.
    for (int r = 0; r < 12; r++) begin
      err_i = tbl[r].err; clr = tbl[r].clr; disp_hold = tbl[r].hold;
      tick();
      chk($sformatf("tbl%0d_ch", r), 32'(disp_ch), 32'(tbl[r].ch));
      chk($sformatf("tbl%0d_lo", r), 32'(disp_lo), 32'(tbl[r].lo));
      chk($sformatf("tbl%0d_hi", r), 32'(disp_hi), 0);
      chk($sformatf("tbl%0d_sat", r), 32'(sat), 32'(tbl[r].sat));
      chk($sformatf("tbl%0d_any", r), 32'(any_err), 32'(tbl[r].any));
    end
    err_i = '0; clr = 1'b0; disp_hold = 1'b0;

    // Hold on channel 1, then a 3-cycle level on err_i[1].
    reached = 0;
    for (int k = 0; k < 16 && !reached; k++) begin
      tick();
      reached = (disp_ch == 1'b1);
    end
    chk("reach_ch1", 32'(reached), 1);
    disp_hold = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t2_any_cleared", 32'(any_err), 0);
    err_i = 2'b10;
    tick();
    chk("t2_any_set", 32'(any_err), 1);
    repeat (2) tick();
    err_i = '0;
    repeat (2) tick();
`ifdef GFX_ERR_MONITOR_EDGE_EN
    chk("t2_lo", 32'(disp_lo), 1);
`else
    chk("t2_lo", 32'(disp_lo), 3);
`endif
    chk("t2_ch_held", 32'(disp_ch), 1);

    // Saturation on channel 0.
    disp_hold = 1'b0;
    reached = 0;
    for (int k = 0; k < 16 && !reached; k++) begin
      tick();
      reached = (disp_ch == 1'b0);
    end
    chk("reach_ch0", 32'(reached), 1);
    disp_hold = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; err_i = 2'b01;
    repeat (20) tick();
    err_i = '0;
    repeat (2) tick();
`ifdef GFX_ERR_MONITOR_EDGE_EN
    chk("t3_lo", 32'(disp_lo), 32'h01);
    chk("t3_sat", 32'(sat), 0);
`else
    chk("t3_lo", 32'(disp_lo), 32'h0F);
    chk("t3_sat", 32'(sat), 32'b01);
`endif
    chk("t3_hi", 32'(disp_hi), 0);

    // clr coinciding with an event drops the event.
    clr = 1'b1; err_i = 2'b01;
    tick();
    clr = 1'b0; err_i = '0;
    tick();
    chk("t4_lo", 32'(disp_lo), 0);
    chk("t4_sat", 32'(sat), 0);
    chk("t4_any", 32'(any_err), 0);
    chk("t4_ch", 32'(disp_ch), 0);

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      err_i     = 2'($urandom);
      clr       = ($urandom_range(0, 31) == 0);
      disp_hold = ($urandom_range(0, 7) == 0);
      tick();
    end
    err_i = '0; clr = 1'b0; disp_hold = 1'b0;

    // Asynchronous reset mid-count.
    err_i = 2'b01;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_disp_ch", 32'(disp_ch), 0);
    chk("arst_disp", {16'h0, disp_hi, disp_lo}, 0);
    chk("arst_sat", 32'(sat), 0);
    chk("arst_any", 32'(any_err), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
`ifdef GFX_ERR_MONITOR_EDGE_EN
    chk("arst_resume_lo", 32'(disp_lo), 1);
`else
    chk("arst_resume_lo", 32'(disp_lo), 2);
`endif
    err_i = '0;

    // Wide counter: plain value, then the 16-bit clamp.
`ifdef GFX_ERR_MONITOR_EDGE_EN
    for (int k = 0; k < 600; k++) begin
      err_b = 2'(k % 2 == 0);
      tick();
    end
`else
    err_b = 2'b01;
    repeat (300) tick();
`endif
    err_b = '0;
    repeat (2) tick();
    chk("wide_300", {16'h0, disp_hi_b, disp_lo_b}, 32'h012C);
`ifndef GFX_ERR_MONITOR_EDGE_EN
    err_b = 2'b01;
    repeat (69700) tick_b();
    err_b = '0;
    repeat (2) tick_b();
    chk("wide_clamp", {16'h0, disp_hi_b, disp_lo_b}, 32'hFFFF);
`endif
    chk("wide_sat", 32'(sat_b), 0);
    chk("wide_any", 32'(any_b), 1);
    chk("wide_ch", 32'(disp_ch_b), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
